// File: rtl/io_request_arbiter_pkg.sv
// Shared IO request/response packet types for the core <-> IO bus path.
package io_request_arbiter_pkg;

    // core_id_t is sized for up to 16 cores; widen here if NUM_CORES grows.
    localparam int CORE_ID_WIDTH    = 4;
    localparam int THREAD_IDX_WIDTH = 2;

    typedef logic [31:0]                 scalar_t;
    typedef logic [THREAD_IDX_WIDTH-1:0] thread_idx_t;
    typedef logic [CORE_ID_WIDTH-1:0]    core_id_t;

    typedef struct packed {
        logic        valid;
        logic        is_store;
        scalar_t     address;
        scalar_t     value;
        thread_idx_t thread_idx;
    } ioreq_packet_t;

    typedef struct packed {
        logic        valid;
        core_id_t    core;
        thread_idx_t thread_idx;
        scalar_t     read_value;
    } iorsp_packet_t;

    localparam scalar_t TIMEOUT_READ_VALUE = 32'hFFFF_FFFF;

endpackage

// File: rtl/io_request_arbiter_if.sv
// Core request/response and IO device bus signals seen by the arbiter.
interface io_request_arbiter_if
    import io_request_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 1
);
    ioreq_packet_t        ior_request [NUM_CORES];
    logic [NUM_CORES-1:0] ia_ready;
    iorsp_packet_t        ia_response;
    logic                 io_read_en;
    logic                 io_write_en;
    scalar_t              io_address;
    scalar_t              io_write_data;
    scalar_t              io_read_data;
    logic                 io_ack;
    logic                 io_timeout;

    modport master (
        input  ior_request, io_read_data, io_ack,
        output ia_ready, ia_response, io_read_en, io_write_en,
               io_address, io_write_data, io_timeout
    );

    modport slave (
        output ior_request, io_read_data, io_ack,
        input  ia_ready, ia_response, io_read_en, io_write_en,
               io_address, io_write_data, io_timeout
    );
endinterface

// File: rtl/arbiter.sv
// Round-robin arbiter: the entry granted last drops to lowest priority.
module arbiter #(
    parameter int NUM_ENTRIES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_ENTRIES-1:0] request,
    input  logic                   update_lru,
    output logic [NUM_ENTRIES-1:0] grant_oh
);
    logic [NUM_ENTRIES-1:0] last_oh;
    logic [NUM_ENTRIES-1:0] above;
    logic [NUM_ENTRIES-1:0] masked;
    logic [NUM_ENTRIES-1:0] pick;
    logic                   seen;

    // Entries strictly above the last winner get first chance, then wrap.
    always_comb begin
        above = '0;
        seen  = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            above[i] = seen;
            seen     = seen | last_oh[i];
        end
        masked   = request & above;
        pick     = (|masked) ? masked : request;
        grant_oh = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_oh <= {1'b1, {(NUM_ENTRIES-1){1'b0}}};
        end else if (update_lru) begin
            last_oh <= grant_oh;
        end
    end
endmodule

// File: rtl/oh_to_idx.sv
// One-hot to binary index encoder.
module oh_to_idx #(
    parameter int NUM_SIGNALS = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic [NUM_SIGNALS-1:0] one_hot,
    output logic [INDEX_WIDTH-1:0] index
);
    always_comb begin
        index = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (one_hot[i]) index = index | INDEX_WIDTH'(i);
        end
    end
endmodule

// File: rtl/io_request_arbiter.sv
// Grants core IO requests round-robin, runs each on the IO bus and broadcasts
// the tagged completion. One transaction outstanding at a time.
//   state   | meaning
//   IDLE    | offering ia_ready to the round-robin winner
//   BUS     | strobe held on the device bus, waiting for io_ack or timeout
//   RESPOND | ia_response.valid high for one cycle
module io_request_arbiter
    import io_request_arbiter_pkg::*;
#(
    parameter int NUM_CORES      = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    io_request_arbiter_if.master   bus
);
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_WARN = CNT_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, BUS, RESPOND} state_t;

    state_t               state;
    logic [NUM_CORES-1:0] req_valid;
    logic [NUM_CORES-1:0] grant_oh;
    core_id_t             grant_idx;
    ioreq_packet_t        grant_req;
    logic                 accept;
    logic [CNT_W-1:0]     wait_cnt;
    core_id_t             lat_core;
    thread_idx_t          lat_thread;
    logic                 lat_store;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) req_valid[i] = bus.ior_request[i].valid;
    end

    always_comb begin
        grant_req = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_oh[i]) grant_req = bus.ior_request[i];
        end
    end

    assign bus.ia_ready = (state == IDLE) ? grant_oh : '0;
    assign accept       = (state == IDLE) && grant_req.valid;

    arbiter #(.NUM_ENTRIES(NUM_CORES)) u_arbiter (
        .clk        (clk),
        .reset      (reset),
        .request    (req_valid),
        .update_lru (accept),
        .grant_oh   (grant_oh)
    );

    oh_to_idx #(.NUM_SIGNALS(NUM_CORES), .INDEX_WIDTH(CORE_ID_WIDTH)) u_grant_idx (
        .one_hot (grant_oh),
        .index   (grant_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            lat_core          <= '0;
            lat_thread        <= '0;
            lat_store         <= 1'b0;
            bus.io_read_en    <= 1'b0;
            bus.io_write_en   <= 1'b0;
            bus.io_address    <= '0;
            bus.io_write_data <= '0;
            bus.io_timeout    <= 1'b0;
            bus.ia_response   <= '0;
        end else begin
            bus.io_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_core          <= grant_idx;
                        lat_thread        <= grant_req.thread_idx;
                        lat_store         <= grant_req.is_store;
                        bus.io_address    <= grant_req.address;
                        bus.io_write_data <= grant_req.value;
                        bus.io_read_en    <= !grant_req.is_store;
                        bus.io_write_en   <= grant_req.is_store;
                        wait_cnt          <= '0;
                        state             <= BUS;
                    end
                end
                BUS: begin
                    // An ack in the final wait cycle still completes normally.
                    if (bus.io_ack) begin
                        bus.ia_response.valid      <= 1'b1;
                        bus.ia_response.core       <= lat_core;
                        bus.ia_response.thread_idx <= lat_thread;
                        bus.ia_response.read_value <= lat_store ? '0 : bus.io_read_data;
                        bus.io_read_en             <= 1'b0;
                        bus.io_write_en            <= 1'b0;
                        state                      <= RESPOND;
                    end else if (wait_cnt == CNT_LAST) begin
                        bus.ia_response.valid      <= 1'b1;
                        bus.ia_response.core       <= lat_core;
                        bus.ia_response.thread_idx <= lat_thread;
                        bus.ia_response.read_value <= TIMEOUT_READ_VALUE;
                        bus.io_read_en             <= 1'b0;
                        bus.io_write_en            <= 1'b0;
                        state                      <= RESPOND;
                    end else begin
                        // Pulse lands in the last wait cycle, one ahead of the response.
                        wait_cnt       <= wait_cnt + 1'b1;
                        bus.io_timeout <= (wait_cnt == CNT_WARN);
                    end
                end
                RESPOND: begin
                    bus.ia_response.valid <= 1'b0;
                    state                 <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_request_arbiter.sv
// Randomized transaction-level bench for io_request_arbiter with two cores.
module tb_io_request_arbiter;
    import io_request_arbiter_pkg::*;

    localparam int NC = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;

    io_request_arbiter_if #(.NUM_CORES(NC)) bus ();

    io_request_arbiter #(.NUM_CORES(NC), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        m_valid [NC];
    logic        m_store [NC];
    logic [31:0] m_addr  [NC];
    logic [31:0] m_val   [NC];
    logic [1:0]  m_thr   [NC];
    int          rr_last;
    int          accepted  [NC];
    int          responded [NC];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int expected_grant();
        for (int k = 1; k <= NC; k++) begin
            int c;
            c = (rr_last + k) % NC;
            if (m_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_request(input int c, input logic st, input logic [31:0] a,
                               input logic [31:0] v, input logic [1:0] th);
        m_valid[c] = 1'b1;
        m_store[c] = st;
        m_addr[c]  = a;
        m_val[c]   = v;
        m_thr[c]   = th;
    endtask

    task automatic new_request(input int c);
        set_request(c, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
    endtask

    task automatic drive_requests();
        for (int c = 0; c < NC; c++) begin
            bus.ior_request[c].valid      = m_valid[c];
            bus.ior_request[c].is_store   = m_store[c];
            bus.ior_request[c].address    = m_addr[c];
            bus.ior_request[c].value      = m_val[c];
            bus.ior_request[c].thread_idx = m_thr[c];
        end
    endtask

    // One IDLE cycle, plus the full transaction if some core is valid.
    // delay < 0 means the device never acks.
    task automatic arb_cycle(input int delay, input logic [31:0] rdata, input bit keep_valid);
        int          g;
        logic        st;
        logic [31:0] a, v, exp_data;
        logic [1:0]  th;
        @(negedge clk);
        drive_requests();
        bus.io_ack       = 1'b0;
        bus.io_read_data = $urandom;
        #1;
        g = expected_grant();
        check("ready_grant", bus.ia_ready, (g < 0) ? 0 : (1 << g));
        check("resp_idle", bus.ia_response.valid, 1'b0);
        check("strobe_idle", {bus.io_read_en, bus.io_write_en}, 2'b00);
        bus.io_ack = 1'($urandom_range(0, 1));
        if (g < 0) return;
        st = m_store[g]; a = m_addr[g]; v = m_val[g]; th = m_thr[g];
        rr_last = g;
        accepted[g]++;
        if (keep_valid) new_request(g);
        else m_valid[g] = 1'b0;
        exp_data = st ? 32'h0 : rdata;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            drive_requests();
            bus.io_ack       = 1'b0;
            bus.io_read_data = $urandom;
            #1;
            check("ready_bus", bus.ia_ready, '0);
            check("read_en", bus.io_read_en, !st);
            check("write_en", bus.io_write_en, st);
            check("address", bus.io_address, a);
            if (st) check("write_data", bus.io_write_data, v);
            check("timeout_pulse", bus.io_timeout, (delay < 0) && (k == TO - 1));
            check("resp_bus", bus.ia_response.valid, 1'b0);
            if (k == delay) begin
                bus.io_ack       = 1'b1;
                bus.io_read_data = rdata;
                break;
            end
            if (k == TO - 1) exp_data = 32'hFFFF_FFFF;
        end
        @(negedge clk);
        drive_requests();
        bus.io_ack = 1'($urandom_range(0, 1));
        #1;
        check("resp_valid", bus.ia_response.valid, 1'b1);
        check("resp_core", bus.ia_response.core, g);
        check("resp_thread", bus.ia_response.thread_idx, th);
        check("resp_data", bus.ia_response.read_value, exp_data);
        check("strobe_resp", {bus.io_read_en, bus.io_write_en, bus.io_timeout}, 3'b000);
        check("ready_resp", bus.ia_ready, '0);
        responded[g]++;
    endtask

    task automatic reset_mid_bus();
        int g;
        set_request(0, 1'b0, 32'hFFFF_0100, 32'h0, 2'd3);
        @(negedge clk);
        drive_requests();
        bus.io_ack = 1'b0;
        #1;
        g = expected_grant();
        check("rst_pre_grant", bus.ia_ready, (g < 0) ? 0 : (1 << g));
        @(negedge clk);
        #1;
        check("rst_pre_strobe", bus.io_read_en, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_async_strobe", bus.io_read_en, 1'b0);
        check("rst_async_resp", bus.ia_response, '0);
        for (int c = 0; c < NC; c++) m_valid[c] = 1'b0;
        drive_requests();
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_no_resp", bus.ia_response.valid, 1'b0);
        end
        reset   = 1'b0;
        rr_last = NC - 1;
    endtask

    initial begin
        reset = 1'b1;
        bus.io_ack = 1'b0;
        bus.io_read_data = '0;
        for (int c = 0; c < NC; c++) begin
            m_valid[c] = 1'b0; m_store[c] = 1'b0; m_addr[c] = '0; m_val[c] = '0; m_thr[c] = '0;
            accepted[c] = 0; responded[c] = 0;
        end
        rr_last = NC - 1;
        drive_requests();
        repeat (2) @(negedge clk);
        #1;
        check("rst_resp", bus.ia_response, '0);
        check("rst_strobes", {bus.io_read_en, bus.io_write_en, bus.io_timeout}, 3'b000);
        check("rst_address", bus.io_address, 32'h0);
        check("rst_wdata", bus.io_write_data, 32'h0);
        reset = 1'b0;

        set_request(0, 1'b0, 32'hFFFF_0004, 32'h0, 2'd2);
        arb_cycle(2, 32'h1234_5678, 1'b0);
        set_request(0, 1'b1, 32'hFFFF_0010, 32'hDEAD_BEEF, 2'd1);
        arb_cycle(0, 32'hCAFE_F00D, 1'b0);
        repeat (3) arb_cycle(0, 32'h0, 1'b0);

        new_request(0);
        new_request(1);
        repeat (8) arb_cycle($urandom_range(0, 3), $urandom, 1'b1);

        arb_cycle(-1, $urandom, 1'b1);
        arb_cycle(1, $urandom, 1'b1);
        arb_cycle(-1, $urandom, 1'b0);
        arb_cycle(0, $urandom, 1'b0);

        reset_mid_bus();
        new_request(1);
        arb_cycle(1, $urandom, 1'b0);

        repeat (60) begin
            int d;
            for (int c = 0; c < NC; c++) begin
                if (!m_valid[c] && ($urandom_range(0, 1) == 1)) new_request(c);
            end
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            arb_cycle(d, $urandom, 1'($urandom_range(0, 1)));
        end

        for (int c = 0; c < NC; c++) check("lost_or_dup", responded[c], accepted[c]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
